// File: rtl/s2p_cfg_loader.sv
// s2p_cfg_loader: shifts a parallel config word MSB-first into a chain of s2p stages,
// then strobes st_clk; holds one pending request and can periodically re-send the last word.
module s2p_cfg_loader #(
    parameter int N_STAGE        = 2,
    parameter int HOLD_CYCLES    = 2,
    parameter int REFRESH_CYCLES = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_valid,
    input  logic [8*N_STAGE-1:0]   cfg_data,
    output logic                   cfg_ready,
    output logic                   sin,
    output logic                   st_clk,
    output logic                   busy,
    output logic                   done
);
    localparam int W  = 8 * N_STAGE;
    localparam int CW = $clog2(W) + 1;
    localparam int HW = $clog2(HOLD_CYCLES + 2);
    localparam int RW = $clog2(REFRESH_CYCLES + 2);

    typedef enum logic [1:0] {IDLE, SHIFT, LATCH, HOLD} state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   sr_q, sr_d, word_q, word_d, pend_data_q, pend_data_d, last_q, last_d;
    logic           pend_q, pend_d, have_q, have_d, req_q, req_d, sin_q, sin_d, st_q, st_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [HW-1:0]  hold_q, hold_d;
    logic [RW-1:0]  tmr_q, tmr_d;
    logic           xfer, decide, start, start_new, expire, refresh;
    logic [W-1:0]   start_word;

    assign xfer       = cfg_valid && cfg_ready;
    assign decide     = (state_q == IDLE) || (state_q == HOLD && hold_q == HW'(HOLD_CYCLES)) ||
                        (state_q == LATCH && HOLD_CYCLES == 0);
    assign expire     = (REFRESH_CYCLES > 0) && (tmr_q == RW'(REFRESH_CYCLES));
    // A request set during the previous shift is stale once that word latches.
    assign refresh    = have_q && (req_q || expire) && state_q != LATCH;
    assign start_new  = decide && !pend_q && xfer;
    assign start      = decide && (pend_q || xfer || refresh);
    assign start_word = pend_q ? pend_data_q : xfer ? cfg_data : last_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = start                                     ? SHIFT :
                  decide                                    ? IDLE  :
                  (state_q == SHIFT && cnt_q == CW'(W))     ? LATCH :
                  (state_q == LATCH)                        ? HOLD  : state_q;
    end

    always_comb begin
        busy      = state_q != IDLE;
        cfg_ready = rst_n && !pend_q;
        sin       = sin_q;
        st_clk    = st_q;
        done      = st_q;
    end

    always_comb begin
        sr_d        = start ? start_word << 1 : state_q == SHIFT ? sr_q << 1 : sr_q;
        sin_d       = start ? start_word[W-1] : (state_q == SHIFT && state_d == SHIFT) ? sr_q[W-1] : 1'b0;
        cnt_d       = start ? CW'(1) : state_q == SHIFT ? cnt_q + CW'(1) : cnt_q;
        word_d      = start ? start_word : word_q;
        st_d        = state_d == LATCH;
        last_d      = state_q == LATCH ? word_q : last_q;
        have_d      = have_q || state_q == LATCH;
        hold_d      = state_d == HOLD ? (state_q == HOLD ? hold_q + HW'(1) : HW'(1)) : '0;
        pend_d      = (decide && pend_q) ? 1'b0 : (xfer && !start_new) ? 1'b1 : pend_q;
        pend_data_d = (xfer && !start_new) ? cfg_data : pend_data_q;
        // Timer saturates one past the threshold so expiry is a single event.
        tmr_d       = state_q == LATCH ? RW'(1) :
                      (have_q && tmr_q <= RW'(REFRESH_CYCLES)) ? tmr_q + RW'(1) : tmr_q;
        req_d       = (start || state_q == LATCH) ? 1'b0 : (expire && have_q) ? 1'b1 : req_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q        <= '0;
            word_q      <= '0;
            pend_data_q <= '0;
            last_q      <= '0;
            pend_q      <= 1'b0;
            have_q      <= 1'b0;
            req_q       <= 1'b0;
            sin_q       <= 1'b0;
            st_q        <= 1'b0;
            cnt_q       <= '0;
            hold_q      <= '0;
            tmr_q       <= '0;
        end else begin
            sr_q        <= sr_d;
            word_q      <= word_d;
            pend_data_q <= pend_data_d;
            last_q      <= last_d;
            pend_q      <= pend_d;
            have_q      <= have_d;
            req_q       <= req_d;
            sin_q       <= sin_d;
            st_q        <= st_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            tmr_q       <= tmr_d;
        end
    end
endmodule

// File: tb/tb_s2p_cfg_loader.sv
// tb_s2p_cfg_loader: three loader builds checked each cycle against a schedule-based model
// (start edge -> bit/strobe/hold windows) plus an s2p chain that must capture the sent word.
module tb_s2p_cfg_loader;
    localparam int NI = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NI-1:0] valid, ready, sin, st, busy, done;
    logic [15:0] data [NI];
    logic [15:0] chain [NI];

    bit act [NI], have [NI], pfull [NI], xf [NI];
    int s [NI], lastl [NI];
    logic [15:0] w [NI], last [NI], pend [NI];
    int c = 0, checks = 0, errors = 0;

    s2p_cfg_loader #(.N_STAGE(2), .HOLD_CYCLES(2), .REFRESH_CYCLES(100)) u0 (
        .clk(clk), .rst_n(rst_n), .cfg_valid(valid[0]), .cfg_data(data[0]), .cfg_ready(ready[0]),
        .sin(sin[0]), .st_clk(st[0]), .busy(busy[0]), .done(done[0]));
    s2p_cfg_loader #(.N_STAGE(2), .HOLD_CYCLES(0), .REFRESH_CYCLES(0)) u1 (
        .clk(clk), .rst_n(rst_n), .cfg_valid(valid[1]), .cfg_data(data[1]), .cfg_ready(ready[1]),
        .sin(sin[1]), .st_clk(st[1]), .busy(busy[1]), .done(done[1]));
    s2p_cfg_loader #(.N_STAGE(1), .HOLD_CYCLES(1), .REFRESH_CYCLES(20)) u2 (
        .clk(clk), .rst_n(rst_n), .cfg_valid(valid[2]), .cfg_data(data[2][7:0]), .cfg_ready(ready[2]),
        .sin(sin[2]), .st_clk(st[2]), .busy(busy[2]), .done(done[2]));

    always #5 clk = ~clk;

    // Stand-in for the s2p chain: shifts sin on every edge.
    always @(posedge clk)
        for (int i = 0; i < NI; i++) chain[i] <= {chain[i][14:0], sin[i]};

    function automatic int wof(int i); return i == 2 ? 8 : 16; endfunction
    function automatic int hof(int i); return i == 0 ? 2 : i == 1 ? 0 : 1; endfunction
    function automatic int rof(int i); return i == 0 ? 100 : i == 1 ? 0 : 20; endfunction
    function automatic logic [15:0] mof(int i); return i == 2 ? 16'h00FF : 16'hFFFF; endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %0h expected %0h", tag, c, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            act[i] = 0; have[i] = 0; pfull[i] = 0; last[i] = '0;
        end
    endtask

    task automatic begin_shift(input int i, input logic [15:0] word);
        act[i] = 1; s[i] = c; w[i] = word & mof(i);
    endtask

    task automatic tick();
        @(negedge clk);
        if (!rst_n) model_reset();
        for (int i = 0; i < NI; i++) begin
            int ww, hh;
            bit in_shift, e_st, e_busy, e_rdy, e_sin;
            ww = wof(i); hh = hof(i);
            in_shift = act[i] && c > s[i] && c <= s[i] + ww;
            e_sin  = in_shift ? w[i][ww + s[i] - c] : 1'b0;
            e_st   = act[i] && c == s[i] + ww + 1;
            e_busy = act[i] && c > s[i] && c <= s[i] + ww + 1 + hh;
            e_rdy  = rst_n && !pfull[i];
            check($sformatf("sin%0d", i), 32'(sin[i]), 32'(e_sin));
            check($sformatf("st_clk%0d", i), 32'(st[i]), 32'(e_st));
            check($sformatf("done%0d", i), 32'(done[i]), 32'(e_st));
            check($sformatf("busy%0d", i), 32'(busy[i]), 32'(e_busy));
            check($sformatf("cfg_ready%0d", i), 32'(ready[i]), 32'(e_rdy));
            if (e_st) check($sformatf("dout%0d", i), 32'(chain[i] & mof(i)), 32'(w[i]));
            xf[i] = valid[i] && e_rdy;
        end
        @(posedge clk);
        if (!rst_n) model_reset();
        else for (int i = 0; i < NI; i++) begin
            int lat;
            lat = s[i] + wof(i) + 1;
            if (act[i] && c == lat) begin
                have[i] = 1; lastl[i] = c; last[i] = w[i];
            end
            if (!act[i] || c >= lat + hof(i)) begin
                if (pfull[i]) begin
                    begin_shift(i, pend[i]); pfull[i] = 0;
                end else if (xf[i]) begin_shift(i, data[i]);
                else if (rof(i) > 0 && have[i] && c >= lastl[i] + rof(i)) begin_shift(i, last[i]);
            end else if (xf[i]) begin
                pfull[i] = 1; pend[i] = data[i] & mof(i);
            end
        end
        c++;
        #1;
    endtask

    initial begin
        int pct;
        valid = '0;
        for (int i = 0; i < NI; i++) data[i] = '0;
        model_reset();
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        data[0] = 16'h1E20; data[1] = 16'h1E20; data[2] = 16'h00A5;
        valid = '1;
        tick();
        valid = '0;
        repeat (5) tick();
        data[0] = 16'h4080; data[1] = 16'h4080; data[2] = 16'h005A;
        valid = '1;
        tick();
        data[0] = 16'hC3F0; data[1] = 16'h0FF0; data[2] = 16'h0096;
        repeat (60) tick();
        valid = '0;
        repeat (40) tick();
        data[0] = 16'h0A14; data[2] = 16'h0014;
        valid[0] = 1'b1; valid[2] = 1'b1;
        tick();
        valid = '0;
        repeat (250) tick();
        for (int k = 0; k < 400; k++) begin
            if (have[0] && !pfull[0] && c == lastl[0] + 100) break;
            tick();
        end
        data[0] = 16'h5AA5; valid[0] = 1'b1;
        tick();
        valid = '0;
        repeat (150) tick();
        data[0] = 16'hBEEF; data[1] = 16'h1234; data[2] = 16'h00C7;
        valid = '1;
        tick();
        valid = '0;
        repeat (8) tick();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (150) tick();
        pct = 30;
        for (int n = 0; n < 4000; n++) begin
            if (n % 500 == 0) pct = $urandom_range(0, 60);
            for (int i = 0; i < NI; i++) begin
                valid[i] = $urandom_range(0, 99) < pct;
                data[i] = 16'($urandom);
            end
            rst_n = $urandom_range(0, 799) != 0;
            tick();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
